// File: rtl/ram_arbiter_pkg.sv
// Shared types for the instruction/data RAM arbiter.
package ram_arbiter_pkg;

  // Width of the per-port starvation counters (limit range 1..15).
  localparam int STARVE_W = 4;

  // Requester identity; also the encoding of the last-grant register.
  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  // One registered RAM command.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    port_t       port;
  } ram_cmd_t;

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational winner select between the fetch and load/store requesters.
// grant_out is one-hot: bit 0 = instruction port, bit 1 = data port.
module arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int MAX_STARVE    = 4
) (
  input  logic [1:0]          valid_in,
  input  port_t               last_grant_in,
  input  logic [STARVE_W-1:0] instr_starve_in,
  input  logic [STARVE_W-1:0] data_starve_in,
  output logic [1:0]          grant_out
);

  localparam logic [STARVE_W-1:0] MAX_S = STARVE_W'(MAX_STARVE);

  logic w_default_data;
  logic w_loser_starved;

  // Pick the normal winner, then let a starved loser override it.
  always_comb begin
    w_default_data  = (DATA_PRIORITY != 0) ? 1'b1 : (last_grant_in == PORT_INSTR);
    w_loser_starved = w_default_data ? (instr_starve_in == MAX_S)
                                     : (data_starve_in == MAX_S);
    grant_out = valid_in;
    if (&valid_in) begin
      grant_out = (w_default_data ^ w_loser_starved) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port word RAM between instruction fetch and load/store.
// Accept in cycle N, command to the RAM in N+1 (RAM acts on negedge),
// response registered back to the granted port for cycle N+2.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int MAX_STARVE    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic [31:0] instr_address_in,
  output logic        instr_resp_valid_out,
  output logic [31:0] instr_read_value_out,
  input  logic        data_valid_in,
  output logic        data_ready_out,
  input  logic [31:0] data_address_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic        data_resp_valid_out,
  output logic [31:0] data_read_value_out,
  output logic [31:0] ram_address_out,
  output logic [3:0]  ram_write_mask_out,
  output logic [31:0] ram_write_value_out,
  input  logic [31:0] ram_read_value_in
);

  localparam logic [STARVE_W-1:0] MAX_S = STARVE_W'(MAX_STARVE);

  logic [1:0]                w_valid;
  logic [1:0]                w_grant;
  logic                      w_contested;
  logic [1:0][STARVE_W-1:0]  w_starve;
  logic [1:0]                w_resp_valid;
  logic [1:0][31:0]          w_read_value;

  port_t    r_last_grant;
  ram_cmd_t r_cmd;
  logic     r_cmd_valid;

  assign w_valid     = {data_valid_in, instr_valid_in};
  assign w_contested = &w_valid;

  arb_pick #(
    .DATA_PRIORITY (DATA_PRIORITY),
    .MAX_STARVE    (MAX_STARVE)
  ) u_arb_pick (
    .valid_in        (w_valid),
    .last_grant_in   (r_last_grant),
    .instr_starve_in (w_starve[0]),
    .data_starve_in  (w_starve[1]),
    .grant_out       (w_grant)
  );

  // Remember the most recent grant for round-robin fairness.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= PORT_INSTR;
    end else if (|w_grant) begin
      r_last_grant <= w_grant[1] ? PORT_DATA : PORT_INSTR;
    end
  end

  // Register the winner's request as the next RAM command; fetches never write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
    end else if (w_grant[1]) begin
      r_cmd       <= '{addr: data_address_in, mask: data_write_mask_in,
                       wdata: data_write_value_in, port: PORT_DATA};
      r_cmd_valid <= 1'b1;
    end else if (w_grant[0]) begin
      r_cmd       <= '{addr: instr_address_in, mask: 4'b0000,
                       wdata: 32'h0, port: PORT_INSTR};
      r_cmd_valid <= 1'b1;
    end else begin
      r_cmd.mask  <= 4'b0000;
      r_cmd_valid <= 1'b0;
    end
  end

  // Per-port starvation counter and response registers.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam port_t PORT = (gi == 1) ? PORT_DATA : PORT_INSTR;

      logic [STARVE_W-1:0] r_starve;
      logic                r_resp_valid;
      logic [31:0]         r_read_value;

      // Count consecutive contested losses (saturating); a win clears it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_starve <= '0;
        end else if (w_grant[gi]) begin
          r_starve <= '0;
        end else if (w_contested && (r_starve != MAX_S)) begin
          r_starve <= r_starve + 1'b1;
        end
      end

      // Capture RAM read data for this port; the value holds between responses.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_resp_valid <= 1'b0;
          r_read_value <= '0;
        end else begin
          r_resp_valid <= r_cmd_valid && (r_cmd.port == PORT);
          if (r_cmd_valid && (r_cmd.port == PORT)) begin
            r_read_value <= ram_read_value_in;
          end
        end
      end

      assign w_starve[gi]     = r_starve;
      assign w_resp_valid[gi] = r_resp_valid;
      assign w_read_value[gi] = r_read_value;
    end
  endgenerate

  assign instr_ready_out      = w_grant[0];
  assign data_ready_out       = w_grant[1];
  assign instr_resp_valid_out = w_resp_valid[0];
  assign instr_read_value_out = w_read_value[0];
  assign data_resp_valid_out  = w_resp_valid[1];
  assign data_read_value_out  = w_read_value[1];

  // Idle cycles must never present a write to the RAM.
  assign ram_address_out     = r_cmd.addr;
  assign ram_write_mask_out  = r_cmd_valid ? r_cmd.mask : 4'b0000;
  assign ram_write_value_out = r_cmd.wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (data-priority and round-robin),
// each paired with a negedge word-RAM model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv, dv;
  logic [31:0] ia, da, dw;
  logic [3:0]  dm;

  logic        a_ir, a_irv, a_dr, a_drv;
  logic [31:0] a_ird, a_drd, a_addr, a_wval;
  logic [3:0]  a_mask;
  logic [31:0] ram_rd_a = '0;
  logic [31:0] mem_a [64];

  logic        b_ir, b_irv, b_dr, b_drv;
  logic [31:0] b_ird, b_drd, b_addr, b_wval;
  logic [3:0]  b_mask;
  logic [31:0] ram_rd_b = '0;
  logic [31:0] mem_b [64];

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.DATA_PRIORITY(1), .MAX_STARVE(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid_in(iv), .instr_ready_out(a_ir), .instr_address_in(ia),
    .instr_resp_valid_out(a_irv), .instr_read_value_out(a_ird),
    .data_valid_in(dv), .data_ready_out(a_dr), .data_address_in(da),
    .data_write_mask_in(dm), .data_write_value_in(dw),
    .data_resp_valid_out(a_drv), .data_read_value_out(a_drd),
    .ram_address_out(a_addr), .ram_write_mask_out(a_mask),
    .ram_write_value_out(a_wval), .ram_read_value_in(ram_rd_a)
  );

  ram_arbiter #(.DATA_PRIORITY(0), .MAX_STARVE(4)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .instr_valid_in(iv), .instr_ready_out(b_ir), .instr_address_in(ia),
    .instr_resp_valid_out(b_irv), .instr_read_value_out(b_ird),
    .data_valid_in(dv), .data_ready_out(b_dr), .data_address_in(da),
    .data_write_mask_in(dm), .data_write_value_in(dw),
    .data_resp_valid_out(b_drv), .data_read_value_out(b_drd),
    .ram_address_out(b_addr), .ram_write_mask_out(b_mask),
    .ram_write_value_out(b_wval), .ram_read_value_in(ram_rd_b)
  );

  // RAM models: read old word and apply byte writes on the falling edge.
  always @(negedge clk) begin
    ram_rd_a <= mem_a[a_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (a_mask[b]) mem_a[a_addr[7:2]][8*b +: 8] <= a_wval[8*b +: 8];
  end

  always @(negedge clk) begin
    ram_rd_b <= mem_b[b_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (b_mask[b]) mem_b[b_addr[7:2]][8*b +: 8] <= b_wval[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  dm;
    logic [31:0] dw;
    logic        e_ir, e_dr;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
    logic [3:0]  e_mask;
  } vec_t;

  function automatic vec_t mk(logic iv_i, logic [31:0] ia_i, logic dv_i, logic [31:0] da_i,
                              logic [3:0] dm_i, logic [31:0] dw_i, logic e_ir_i, logic e_dr_i,
                              logic e_irv_i, logic [31:0] e_ird_i, logic e_drv_i,
                              logic [31:0] e_drd_i, logic [3:0] e_mask_i);
    vec_t v;
    v.iv = iv_i; v.ia = ia_i; v.dv = dv_i; v.da = da_i; v.dm = dm_i; v.dw = dw_i;
    v.e_ir = e_ir_i; v.e_dr = e_dr_i; v.e_irv = e_irv_i; v.e_ird = e_ird_i;
    v.e_drv = e_drv_i; v.e_drd = e_drd_i; v.e_mask = e_mask_i;
    return v;
  endfunction

  vec_t vecs [11];
  logic exp_b_data [10];

  task automatic drive_idle();
    iv = 1'b0; ia = '0; dv = 1'b0; da = '0; dm = '0; dw = '0;
  endtask

  initial begin
    drive_idle();
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[4] = 32'hDEADBEEF; mem_a[5] = 32'h55555555;
    mem_a[8] = 32'hAAAAAAAA; mem_a[12] = 32'h12345678;
    mem_b[4] = 32'hDEADBEEF; mem_b[5] = 32'h55555555;
    mem_b[8] = 32'hAAAAAAAA; mem_b[12] = 32'h12345678;

    //            iv ia        dv da        dm       dw            ir dr irv ird           drv drd           mask
    vecs[0]  = mk(1, 32'h10,   0, 32'h0,    4'b0000, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        4'b0000);
    vecs[1]  = mk(0, 32'h0,    1, 32'h20,   4'b0101, 32'h11223344, 0, 1, 0, 32'h0,        0, 32'h0,        4'b0000);
    vecs[2]  = mk(0, 32'h0,    1, 32'h20,   4'b0000, 32'h0,        0, 1, 1, 32'hDEADBEEF, 0, 32'h0,        4'b0101);
    vecs[3]  = mk(0, 32'h0,    0, 32'h0,    4'b0000, 32'h0,        0, 0, 0, 32'hDEADBEEF, 1, 32'hAAAAAAAA, 4'b0000);
    vecs[4]  = mk(0, 32'h0,    0, 32'h0,    4'b0000, 32'h0,        0, 0, 0, 32'hDEADBEEF, 1, 32'hAA22AA44, 4'b0000);
    vecs[5]  = mk(1, 32'h14,   1, 32'h30,   4'b0000, 32'h0,        0, 1, 0, 32'hDEADBEEF, 0, 32'hAA22AA44, 4'b0000);
    vecs[6]  = mk(1, 32'h14,   1, 32'h10,   4'b0000, 32'h0,        0, 1, 0, 32'hDEADBEEF, 0, 32'hAA22AA44, 4'b0000);
    vecs[7]  = mk(1, 32'h14,   0, 32'h0,    4'b0000, 32'h0,        1, 0, 0, 32'hDEADBEEF, 1, 32'h12345678, 4'b0000);
    vecs[8]  = mk(0, 32'h0,    0, 32'h0,    4'b0000, 32'h0,        0, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'b0000);
    vecs[9]  = mk(0, 32'h0,    0, 32'h0,    4'b0000, 32'h0,        0, 0, 1, 32'h55555555, 0, 32'hDEADBEEF, 4'b0000);
    vecs[10] = mk(0, 32'h0,    0, 32'h0,    4'b0000, 32'h0,        0, 0, 0, 32'h55555555, 0, 32'hDEADBEEF, 4'b0000);

    // Reset state.
    #2;
    chk("rst_instr_ready", a_ir, 0);
    chk("rst_data_ready", a_dr, 0);
    chk("rst_instr_resp_valid", a_irv, 0);
    chk("rst_data_resp_valid", a_drv, 0);
    chk("rst_instr_rdata", a_ird, 0);
    chk("rst_data_rdata", a_drd, 0);
    chk("rst_ram_addr", a_addr, 0);
    chk("rst_ram_mask", a_mask, 0);
    chk("rst_ram_wval", a_wval, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven single and mixed transactions on the data-priority instance.
    for (int r = 0; r < 11; r++) begin
      @(posedge clk); #1;
      iv = vecs[r].iv; ia = vecs[r].ia; dv = vecs[r].dv;
      da = vecs[r].da; dm = vecs[r].dm; dw = vecs[r].dw;
      @(negedge clk);
      $display("row %0d: iv=%0d dv=%0d ir=%0d dr=%0d irv=%0d ird=%h drv=%0d drd=%h mask=%b",
               r, iv, dv, a_ir, a_dr, a_irv, a_ird, a_drv, a_drd, a_mask);
      chk($sformatf("row%0d_instr_ready", r), a_ir, vecs[r].e_ir);
      chk($sformatf("row%0d_data_ready", r), a_dr, vecs[r].e_dr);
      chk($sformatf("row%0d_instr_resp_valid", r), a_irv, vecs[r].e_irv);
      chk($sformatf("row%0d_instr_rdata", r), a_ird, vecs[r].e_ird);
      chk($sformatf("row%0d_data_resp_valid", r), a_drv, vecs[r].e_drv);
      chk($sformatf("row%0d_data_rdata", r), a_drd, vecs[r].e_drd);
      chk($sformatf("row%0d_ram_mask", r), a_mask, vecs[r].e_mask);
    end

    // Both ports valid continuously: priority instance D,D,D,D,I; round-robin D,I,...
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      iv = 1'b1; ia = 32'h10; dv = 1'b1; da = 32'h14; dm = 4'b0000; dw = '0;
      @(negedge clk);
      exp_b_data[k] = (k % 2 == 0);
      $display("contest %0d: prio grant=%s rr grant=%s rr_irv=%0d rr_drv=%0d",
               k, a_dr ? "D" : "I", b_dr ? "D" : "I", b_irv, b_drv);
      chk($sformatf("prio_data_ready_%0d", k), a_dr, (k % 5 != 4));
      chk($sformatf("prio_instr_ready_%0d", k), a_ir, (k % 5 == 4));
      chk($sformatf("rr_data_ready_%0d", k), b_dr, exp_b_data[k]);
      chk($sformatf("rr_instr_ready_%0d", k), b_ir, !exp_b_data[k]);
      if (k >= 2) begin
        chk($sformatf("rr_data_resp_%0d", k), b_drv, exp_b_data[k-2]);
        chk($sformatf("rr_instr_resp_%0d", k), b_irv, !exp_b_data[k-2]);
        if (exp_b_data[k-2]) chk($sformatf("rr_data_rdata_%0d", k), b_drd, 32'h55555555);
        else                 chk($sformatf("rr_instr_rdata_%0d", k), b_ird, 32'hDEADBEEF);
      end
    end

    // Drain, then ten idle cycles with no write strobe on either RAM.
    @(posedge clk); #1;
    drive_idle();
    repeat (2) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      $display("idle %0d: prio mask=%b rr mask=%b", k, a_mask, b_mask);
      chk($sformatf("idle_prio_mask_%0d", k), a_mask, 0);
      chk($sformatf("idle_rr_mask_%0d", k), b_mask, 0);
      @(posedge clk);
    end
    chk("idle_mem_w4", mem_a[4], 32'hDEADBEEF);
    chk("idle_mem_w8", mem_a[8], 32'hAA22AA44);
    chk("idle_mem_w12", mem_a[12], 32'h12345678);

    // Store accepted, then reset in the next cycle: the write must never reach the RAM.
    #1;
    dv = 1'b1; da = 32'h30; dm = 4'b1111; dw = 32'hCAFEF00D;
    @(negedge clk);
    $display("reset_store: dr=%0d", a_dr);
    chk("rst_store_accepted", a_dr, 1);
    @(posedge clk); #1;
    drive_idle();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mask_a", a_mask, 0);
    chk("rst_mid_mask_b", b_mask, 0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("rst_mid_mem_a", mem_a[12], 32'h12345678);
    chk("rst_mid_mem_b", mem_b[12], 32'h12345678);
    chk("rst_mid_data_resp", a_drv, 0);
    chk("rst_mid_data_rdata", a_drd, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_data_resp", a_drv, 0);
      chk("post_rst_mask", a_mask, 0);
    end
    chk("post_rst_mem_a", mem_a[12], 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
